control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Hardwired Moore control unit for the simple-CPU datapath.
- Receives the instruction register (IR) word and the CON flip-flop result from the datapath.
- Drives every datapath control strobe, stepping through fetch, decode and per-class execute states, one state per clock.
- Sits beside the datapath at the top level; its outputs connect 1:1 to the datapath control inputs of the same names.

Parameters:
MEM_WAIT, 1, cycles Read or Write is held for a memory access (1..15)
OP_ADD, 5'b00011, ALU operation code used for address/offset/PC addition

Ports:
clock  input  1  system clock, rising edge
clear  input  1  asynchronous active-high reset
ir  input  32  IR contents; opcode = ir[31:27]
con_ff  input  1  CON flip-flop output from datapath
PCout, ZLowout, MDRout, Cout  output  1  bus drivers
MAR_enable, PC_enable, MDR_enable, IR_enable, Y_enable, Z_low_enable, Z_high_enable  output  1  register loads
IncPC, Read, Write  output  1  PC increment, memory read, memory write
GRA, GRB, GRC, Rin, Rout, BAout  output  1  register select / register-file strobes
CON_in  output  1  CON flip-flop load
operation  output  5  ALU opcode
run  output  1  1 while executing, 0 when halted

Behaviour:
- Outputs are a pure function of the registered state (Moore). Unlisted outputs are 0 in every state. operation defaults to 5'b00000.
- Reset: clear asynchronously forces state to F0, clears the wait counter, and sets run=1. During clear all strobes are 0.
- Fetch:
  - F0: PCout, MAR_enable, IncPC.
  - F1: Read, MDR_enable, held MEM_WAIT cycles via a 4-bit down-counter loaded on entry.
  - F2: MDRout, IR_enable.
  - F2 is followed by E0, which decodes ir[31:27].
- Opcode classes:
  - ld 00000, ldi 00001, st 00010.
  - R-ALU 00011..01001.
  - addi 01010, andi 01011, ori 01100.
  - br 10010.
  - nop 11010, halt 11011.
  - All other opcodes are treated as nop.
- ld / ldi / st common steps:
  - E0: GRB, BAout, Y_enable.
  - E1: Cout, operation=OP_ADD, Z_low_enable.
- ld:
  - E2: ZLowout, MAR_enable.
  - E3: Read, MDR_enable for MEM_WAIT cycles.
  - E4: MDRout, GRA, Rin.
  - E4 returns to F0.
- ldi:
  - E2: ZLowout, GRA, Rin.
  - E2 returns to F0.
- st:
  - E2: ZLowout, MAR_enable.
  - E3: GRA, Rout, MDR_enable, with Read=0 so the MDR loads from the bus.
  - E4: Write for MEM_WAIT cycles.
  - E4 returns to F0.
- R-ALU:
  - E0: GRB, Rout, Y_enable.
  - E1: GRC, Rout, operation=ir[31:27], Z_low_enable, Z_high_enable.
  - E2: ZLowout, GRA, Rin.
- addi / andi / ori:
  - E0: GRB, Rout, Y_enable.
  - E1: Cout, Z_low_enable, with operation = 00011 / 00101 / 00110 respectively.
  - E2: ZLowout, GRA, Rin.
- br:
  - E0: GRA, Rout, CON_in.
  - E1: PCout, Y_enable.
  - E2: Cout, operation=OP_ADD, Z_low_enable.
  - E3: if con_ff=1, assert ZLowout and PC_enable; otherwise all strobes 0.
  - con_ff is sampled in E3 only.
- nop / illegal: E0 asserts nothing and returns to F0.
- halt: E0 goes to HALT. HALT asserts run=0 and no strobes, and holds until clear.
- Memory wait counter:
  - A MEM_WAIT value of 0 is treated as 1.
  - The counter decrements each cycle while in F1 / ld-E3 / st-E4.
  - The state advances on the cycle the counter reaches 1.
- ir is sampled only in E0 and later execute states. Changes to ir during F0–F2 have no effect until E0.
- Mutual exclusion: at most one bus-driver strobe (PCout, ZLowout, MDRout, Cout, Rout) is high in any state. A bench assertion must check this.
- Reset mid-instruction (any state) returns to F0 on the next rising edge after clear deasserts. No partial Rin/Write may occur after clear rises.
- Instruction latency (MEM_WAIT=1):
  - fetch 3 cycles;
  - ldi and ALU ops 6 cycles total;
  - ld and st 8 cycles;
  - br 7 cycles.

Test Plan:
- Reset, then release with MEM_WAIT=1 → F0 strobes (PCout, MAR_enable, IncPC) on the first cycle, Read+MDR_enable on the second, MDRout+IR_enable on the third; run=1.
- ir=0x18000000 (add) → E1 shows GRC, Rout, operation=00011, Z_low_enable, Z_high_enable; E2 shows ZLowout+Rin; back to F0 at cycle 7.
- ld with MEM_WAIT=3 → Read held exactly 3 cycles in F1 and 3 in E3; MDRout+GRA+Rin in the final state; 12 cycles total.
- br with con_ff=1, then repeated with con_ff=0 → E3 asserts ZLowout+PC_enable only in the taken case; all strobes 0 otherwise.
- halt (opcode 11011) → run falls to 0 the cycle after E0 and strobes stay 0 for 20 cycles; asserting clear returns run=1 and state F0.
- Assert clear asynchronously during st E4 (Write high) → Write drops immediately (combinationally with clear); no further Write; fetch restarts.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the simple-CPU datapath: fetch, decode and
// per-class execute states, one state per clock, with a memory-wait down-counter.
module control_sequencer #(
  parameter int unsigned MEM_WAIT = 1,
  parameter logic [4:0]  OP_ADD   = 5'b00011
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        con_ff,
  output logic        PCout,
  output logic        ZLowout,
  output logic        MDRout,
  output logic        Cout,
  output logic        MAR_enable,
  output logic        PC_enable,
  output logic        MDR_enable,
  output logic        IR_enable,
  output logic        Y_enable,
  output logic        Z_low_enable,
  output logic        Z_high_enable,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        GRA,
  output logic        GRB,
  output logic        GRC,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        CON_in,
  output logic [4:0]  operation,
  output logic        run,
  output logic [3:0]  dbg_state_o
);

  typedef enum logic [3:0] {
    S_F0, S_F1, S_F2, S_E0, S_E1, S_E2, S_E3, S_E4, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    C_LD, C_LDI, C_ST, C_ALU, C_IMM, C_BR, C_NOP, C_HALT
  } cls_e;

  typedef struct packed {
    logic PCout, ZLowout, MDRout, Cout;
    logic MAR_enable, PC_enable, MDR_enable, IR_enable;
    logic Y_enable, Z_low_enable, Z_high_enable;
    logic IncPC, Read, Write;
    logic GRA, GRB, GRC, Rin, Rout, BAout, CON_in;
    logic [4:0] operation;
  } ctl_t;

  localparam logic [3:0] WAIT_LOAD = (MEM_WAIT == 0) ? 4'd1 : 4'(MEM_WAIT);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  cls_e       cls;
  logic [4:0] opcode, imm_op;
  ctl_t       ctl, ctl_g;
  logic       unused_ir_bits;

  assign opcode         = ir[31:27];
  assign unused_ir_bits = ^ir[26:0];

  always_comb begin
    cls    = C_NOP;
    imm_op = OP_ADD;
    if (opcode == 5'b00000)                  cls = C_LD;
    else if (opcode == 5'b00001)             cls = C_LDI;
    else if (opcode == 5'b00010)             cls = C_ST;
    else if (opcode inside {[5'd3:5'd9]})    cls = C_ALU;
    else if (opcode inside {[5'd10:5'd12]}) begin
      cls = C_IMM;
      if (opcode == 5'b01011)      imm_op = 5'b00101;
      else if (opcode == 5'b01100) imm_op = 5'b00110;
    end
    else if (opcode == 5'b10010)             cls = C_BR;
    else if (opcode == 5'b11011)             cls = C_HALT;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= S_F0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctl     = '0;
    case (state_q)
      S_F0: begin
        ctl.PCout = 1'b1; ctl.MAR_enable = 1'b1; ctl.IncPC = 1'b1;
        state_d = S_F1;
        cnt_d   = WAIT_LOAD;
      end
      S_F1: begin
        ctl.Read = 1'b1; ctl.MDR_enable = 1'b1;
        if (cnt_q <= 4'd1) state_d = S_F2;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_F2: begin
        ctl.MDRout = 1'b1; ctl.IR_enable = 1'b1;
        state_d = S_E0;
      end
      S_E0: begin
        state_d = S_E1;
        case (cls)
          C_LD, C_LDI, C_ST: begin ctl.GRB = 1'b1; ctl.BAout = 1'b1; ctl.Y_enable = 1'b1; end
          C_ALU, C_IMM:      begin ctl.GRB = 1'b1; ctl.Rout = 1'b1; ctl.Y_enable = 1'b1; end
          C_BR:              begin ctl.GRA = 1'b1; ctl.Rout = 1'b1; ctl.CON_in = 1'b1; end
          C_HALT:            state_d = S_HALT;
          default:           state_d = S_F0;
        endcase
      end
      S_E1: begin
        state_d = S_E2;
        case (cls)
          C_LD, C_LDI, C_ST: begin ctl.Cout = 1'b1; ctl.operation = OP_ADD; ctl.Z_low_enable = 1'b1; end
          C_ALU: begin
            ctl.GRC = 1'b1; ctl.Rout = 1'b1; ctl.operation = opcode;
            ctl.Z_low_enable = 1'b1; ctl.Z_high_enable = 1'b1;
          end
          C_IMM:   begin ctl.Cout = 1'b1; ctl.operation = imm_op; ctl.Z_low_enable = 1'b1; end
          C_BR:    begin ctl.PCout = 1'b1; ctl.Y_enable = 1'b1; end
          default: state_d = S_F0;
        endcase
      end
      S_E2: begin
        state_d = S_F0;
        case (cls)
          C_LD, C_ST: begin
            ctl.ZLowout = 1'b1; ctl.MAR_enable = 1'b1;
            state_d = S_E3;
            cnt_d   = WAIT_LOAD;
          end
          C_LDI, C_ALU, C_IMM: begin ctl.ZLowout = 1'b1; ctl.GRA = 1'b1; ctl.Rin = 1'b1; end
          C_BR: begin
            ctl.Cout = 1'b1; ctl.operation = OP_ADD; ctl.Z_low_enable = 1'b1;
            state_d = S_E3;
          end
          default: state_d = S_F0;
        endcase
      end
      S_E3: begin
        state_d = S_F0;
        case (cls)
          C_LD: begin
            ctl.Read = 1'b1; ctl.MDR_enable = 1'b1;
            if (cnt_q <= 4'd1) state_d = S_E4;
            else begin
              state_d = S_E3;
              cnt_d   = cnt_q - 4'd1;
            end
          end
          // Read stays low so the MDR captures the register value from the bus.
          C_ST: begin
            ctl.GRA = 1'b1; ctl.Rout = 1'b1; ctl.MDR_enable = 1'b1;
            state_d = S_E4;
            cnt_d   = WAIT_LOAD;
          end
          C_BR: begin
            ctl.ZLowout   = con_ff;
            ctl.PC_enable = con_ff;
          end
          default: state_d = S_F0;
        endcase
      end
      S_E4: begin
        state_d = S_F0;
        case (cls)
          C_LD: begin ctl.MDRout = 1'b1; ctl.GRA = 1'b1; ctl.Rin = 1'b1; end
          C_ST: begin
            ctl.Write = 1'b1;
            if (cnt_q > 4'd1) begin
              state_d = S_E4;
              cnt_d   = cnt_q - 4'd1;
            end
          end
          default: state_d = S_F0;
        endcase
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_F0;
    endcase
  end

  // Strobes are forced low while clear is high so an in-flight Rin/Write dies at once.
  assign ctl_g = clear ? '0 : ctl;

  assign PCout         = ctl_g.PCout;
  assign ZLowout       = ctl_g.ZLowout;
  assign MDRout        = ctl_g.MDRout;
  assign Cout          = ctl_g.Cout;
  assign MAR_enable    = ctl_g.MAR_enable;
  assign PC_enable     = ctl_g.PC_enable;
  assign MDR_enable    = ctl_g.MDR_enable;
  assign IR_enable     = ctl_g.IR_enable;
  assign Y_enable      = ctl_g.Y_enable;
  assign Z_low_enable  = ctl_g.Z_low_enable;
  assign Z_high_enable = ctl_g.Z_high_enable;
  assign IncPC         = ctl_g.IncPC;
  assign Read          = ctl_g.Read;
  assign Write         = ctl_g.Write;
  assign GRA           = ctl_g.GRA;
  assign GRB           = ctl_g.GRB;
  assign GRC           = ctl_g.GRC;
  assign Rin           = ctl_g.Rin;
  assign Rout          = ctl_g.Rout;
  assign BAout         = ctl_g.BAout;
  assign CON_in        = ctl_g.CON_in;
  assign operation     = ctl_g.operation;
  assign run           = (state_q != S_HALT);
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-cycle expected strobe words are
// queued by the stimulus and compared by a negedge monitor.
module tb_control_sequencer;

  localparam int W = 28;

  localparam logic [26:0] B_RUN    = 27'd1 << 26;
  localparam logic [26:0] B_PCOUT  = 27'd1 << 20;
  localparam logic [26:0] B_ZLOUT  = 27'd1 << 19;
  localparam logic [26:0] B_MDROUT = 27'd1 << 18;
  localparam logic [26:0] B_COUT   = 27'd1 << 17;
  localparam logic [26:0] B_MARE   = 27'd1 << 16;
  localparam logic [26:0] B_PCE    = 27'd1 << 15;
  localparam logic [26:0] B_MDRE   = 27'd1 << 14;
  localparam logic [26:0] B_IRE    = 27'd1 << 13;
  localparam logic [26:0] B_YE     = 27'd1 << 12;
  localparam logic [26:0] B_ZLE    = 27'd1 << 11;
  localparam logic [26:0] B_ZHE    = 27'd1 << 10;
  localparam logic [26:0] B_INCPC  = 27'd1 << 9;
  localparam logic [26:0] B_READ   = 27'd1 << 8;
  localparam logic [26:0] B_WRITE  = 27'd1 << 7;
  localparam logic [26:0] B_GRA    = 27'd1 << 6;
  localparam logic [26:0] B_GRB    = 27'd1 << 5;
  localparam logic [26:0] B_GRC    = 27'd1 << 4;
  localparam logic [26:0] B_RIN    = 27'd1 << 3;
  localparam logic [26:0] B_ROUT   = 27'd1 << 2;
  localparam logic [26:0] B_BAOUT  = 27'd1 << 1;
  localparam logic [26:0] B_CONIN  = 27'd1 << 0;

  localparam logic [31:0] I_LD   = 32'h0000_0000;
  localparam logic [31:0] I_LDI  = 32'h0800_0000;
  localparam logic [31:0] I_ST   = 32'h1000_0000;
  localparam logic [31:0] I_ADD  = 32'h1800_0000;
  localparam logic [31:0] I_SUB  = 32'h2000_0000;
  localparam logic [31:0] I_ANDI = 32'h5800_0000;
  localparam logic [31:0] I_ORI  = 32'h6000_0000;
  localparam logic [31:0] I_BR   = 32'h9000_0000;
  localparam logic [31:0] I_NOP  = 32'hD000_0000;
  localparam logic [31:0] I_HALT = 32'hD800_0000;
  localparam logic [31:0] I_ILL  = 32'hF800_0000;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [31:0] ir = '0;
  logic        con_ff = 1'b0;

  logic PCout_a, ZLowout_a, MDRout_a, Cout_a, MAR_a, PCe_a, MDRe_a, IRe_a, Ye_a, ZLe_a, ZHe_a;
  logic IncPC_a, Read_a, Write_a, GRA_a, GRB_a, GRC_a, Rin_a, Rout_a, BAout_a, CONin_a, run_a;
  logic [4:0] op_a;
  logic [3:0] dbg_a;
  logic PCout_b, ZLowout_b, MDRout_b, Cout_b, MAR_b, PCe_b, MDRe_b, IRe_b, Ye_b, ZLe_b, ZHe_b;
  logic IncPC_b, Read_b, Write_b, GRA_b, GRB_b, GRC_b, Rin_b, Rout_b, BAout_b, CONin_b, run_b;
  logic [4:0] op_b;
  logic [3:0] dbg_b;

  logic [26:0] out_a, out_b;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_ent;
  int checks = 0;
  int failures = 0;
  string tname = "reset";

  // clock / reset
  always #5 clock = ~clock;

  control_sequencer #(.MEM_WAIT(1)) dut_a (
    .clock(clock), .clear(clear), .ir(ir), .con_ff(con_ff),
    .PCout(PCout_a), .ZLowout(ZLowout_a), .MDRout(MDRout_a), .Cout(Cout_a),
    .MAR_enable(MAR_a), .PC_enable(PCe_a), .MDR_enable(MDRe_a), .IR_enable(IRe_a),
    .Y_enable(Ye_a), .Z_low_enable(ZLe_a), .Z_high_enable(ZHe_a),
    .IncPC(IncPC_a), .Read(Read_a), .Write(Write_a),
    .GRA(GRA_a), .GRB(GRB_a), .GRC(GRC_a), .Rin(Rin_a), .Rout(Rout_a), .BAout(BAout_a),
    .CON_in(CONin_a), .operation(op_a), .run(run_a), .dbg_state_o(dbg_a)
  );

  control_sequencer #(.MEM_WAIT(3)) dut_b (
    .clock(clock), .clear(clear), .ir(ir), .con_ff(con_ff),
    .PCout(PCout_b), .ZLowout(ZLowout_b), .MDRout(MDRout_b), .Cout(Cout_b),
    .MAR_enable(MAR_b), .PC_enable(PCe_b), .MDR_enable(MDRe_b), .IR_enable(IRe_b),
    .Y_enable(Ye_b), .Z_low_enable(ZLe_b), .Z_high_enable(ZHe_b),
    .IncPC(IncPC_b), .Read(Read_b), .Write(Write_b),
    .GRA(GRA_b), .GRB(GRB_b), .GRC(GRC_b), .Rin(Rin_b), .Rout(Rout_b), .BAout(BAout_b),
    .CON_in(CONin_b), .operation(op_b), .run(run_b), .dbg_state_o(dbg_b)
  );

  assign out_a = {run_a, op_a, PCout_a, ZLowout_a, MDRout_a, Cout_a, MAR_a, PCe_a, MDRe_a,
                  IRe_a, Ye_a, ZLe_a, ZHe_a, IncPC_a, Read_a, Write_a, GRA_a, GRB_a, GRC_a,
                  Rin_a, Rout_a, BAout_a, CONin_a};
  assign out_b = {run_b, op_b, PCout_b, ZLowout_b, MDRout_b, Cout_b, MAR_b, PCe_b, MDRe_b,
                  IRe_b, Ye_b, ZLe_b, ZHe_b, IncPC_b, Read_b, Write_b, GRA_b, GRB_b, GRC_b,
                  Rin_b, Rout_b, BAout_b, CONin_b};

  always @(negedge clock) begin
    assert ($onehot0({PCout_a, ZLowout_a, MDRout_a, Cout_a, Rout_a}))
      else $error("bus contention on dut_a");
    assert ($onehot0({PCout_b, ZLowout_b, MDRout_b, Cout_b, Rout_b}))
      else $error("bus contention on dut_b");
  end

  function automatic logic [26:0] op(input logic [4:0] o);
    return {1'b0, o, 21'd0};
  endfunction

  task automatic check(input string name, input logic [26:0] got, input logic [26:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL %s [%s]: got=%h expected=%h", name, tname, got, exp_v);
    end
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      mon_ent = exp_q.pop_front();
      check("cycle", mon_ent[27] ? out_b : out_a, mon_ent[26:0]);
    end
  end

  // driver tasks
  task automatic want(input logic sel, input logic [26:0] v);
    exp_q.push_back({sel, v});
  endtask

  task automatic fetch_a();
    want(1'b0, B_RUN | B_PCOUT | B_MARE | B_INCPC);
    want(1'b0, B_RUN | B_READ | B_MDRE);
    want(1'b0, B_RUN | B_MDROUT | B_IRE);
  endtask

  // Runs n cycles; ir switches to ir_exec during fetch, which must not matter.
  task automatic go(input logic [31:0] ir_exec, input int n);
    for (int i = 1; i <= n; i++) begin
      @(posedge clock);
      if (i == 2) begin
        #1;
        ir = ir_exec;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    clear = 1'b1;
    #1;
    check("clear_outputs_a", out_a, B_RUN);
    check("clear_outputs_b", out_b, B_RUN);
    @(posedge clock);
    @(posedge clock);
    #1;
    clear = 1'b0;
  endtask

  task automatic mem_a(input string nm, input logic [31:0] instr, input logic [26:0] e2,
                       input logic [26:0] e3, input logic [26:0] e4);
    tname = nm;
    ir = instr;
    fetch_a();
    want(1'b0, B_RUN | B_GRB | B_BAOUT | B_YE);
    want(1'b0, B_RUN | B_COUT | op(5'b00011) | B_ZLE);
    want(1'b0, B_RUN | e2);
    want(1'b0, B_RUN | e3);
    want(1'b0, B_RUN | e4);
    go(instr, 8);
  endtask

  task automatic alu_a(input string nm, input logic [31:0] fetch_ir, input logic [31:0] instr,
                       input logic [26:0] e1);
    tname = nm;
    ir = fetch_ir;
    fetch_a();
    want(1'b0, B_RUN | B_GRB | B_ROUT | B_YE);
    want(1'b0, B_RUN | e1);
    want(1'b0, B_RUN | B_ZLOUT | B_GRA | B_RIN);
    go(instr, 6);
  endtask

  task automatic br_a(input string nm, input logic taken);
    tname = nm;
    ir = I_BR;
    con_ff = taken;
    fetch_a();
    want(1'b0, B_RUN | B_GRA | B_ROUT | B_CONIN);
    want(1'b0, B_RUN | B_PCOUT | B_YE);
    want(1'b0, B_RUN | B_COUT | op(5'b00011) | B_ZLE);
    want(1'b0, taken ? (B_RUN | B_ZLOUT | B_PCE) : B_RUN);
    go(I_BR, 7);
    con_ff = 1'b0;
  endtask

  task automatic short_a(input string nm, input logic [31:0] instr);
    tname = nm;
    ir = instr;
    fetch_a();
    want(1'b0, B_RUN);
    go(instr, 4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout with %0d expected entries pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clock);
    #1;
    do_reset();

    alu_a("add_ir_late", I_HALT, I_ADD,
          B_GRC | B_ROUT | op(5'b00011) | B_ZLE | B_ZHE);
    alu_a("sub", I_SUB, I_SUB, B_GRC | B_ROUT | op(5'b00100) | B_ZLE | B_ZHE);
    alu_a("andi", I_ANDI, I_ANDI, B_COUT | op(5'b00101) | B_ZLE);
    alu_a("ori", I_ORI, I_ORI, B_COUT | op(5'b00110) | B_ZLE);

    tname = "ldi";
    ir = I_LDI;
    fetch_a();
    want(1'b0, B_RUN | B_GRB | B_BAOUT | B_YE);
    want(1'b0, B_RUN | B_COUT | op(5'b00011) | B_ZLE);
    want(1'b0, B_RUN | B_ZLOUT | B_GRA | B_RIN);
    go(I_LDI, 6);

    mem_a("ld_w1", I_LD, B_ZLOUT | B_MARE, B_READ | B_MDRE, B_MDROUT | B_GRA | B_RIN);
    mem_a("st_w1", I_ST, B_ZLOUT | B_MARE, B_GRA | B_ROUT | B_MDRE, B_WRITE);
    br_a("br_taken", 1'b1);
    br_a("br_not_taken", 1'b0);
    short_a("nop", I_NOP);
    short_a("illegal", I_ILL);

    // clear arrives mid-cycle while st is writing
    tname = "st_clear_e4";
    ir = I_ST;
    fetch_a();
    want(1'b0, B_RUN | B_GRB | B_BAOUT | B_YE);
    want(1'b0, B_RUN | B_COUT | op(5'b00011) | B_ZLE);
    want(1'b0, B_RUN | B_ZLOUT | B_MARE);
    want(1'b0, B_RUN | B_GRA | B_ROUT | B_MDRE);
    want(1'b0, B_RUN | B_WRITE);
    repeat (7) @(posedge clock);
    @(negedge clock);
    #1;
    clear = 1'b1;
    #1;
    check("write_drops_on_clear", out_a, B_RUN);
    @(posedge clock);
    #1;
    check("no_write_after_clear", out_a, B_RUN);
    clear = 1'b0;
    short_a("restart_after_clear", I_NOP);

    // ld with a three-cycle memory wait
    do_reset();
    tname = "ld_w3";
    ir = I_LD;
    want(1'b1, B_RUN | B_PCOUT | B_MARE | B_INCPC);
    repeat (3) want(1'b1, B_RUN | B_READ | B_MDRE);
    want(1'b1, B_RUN | B_MDROUT | B_IRE);
    want(1'b1, B_RUN | B_GRB | B_BAOUT | B_YE);
    want(1'b1, B_RUN | B_COUT | op(5'b00011) | B_ZLE);
    want(1'b1, B_RUN | B_ZLOUT | B_MARE);
    repeat (3) want(1'b1, B_RUN | B_READ | B_MDRE);
    want(1'b1, B_RUN | B_MDROUT | B_GRA | B_RIN);
    want(1'b1, B_RUN | B_PCOUT | B_MARE | B_INCPC);
    go(I_LD, 13);

    do_reset();
    tname = "halt";
    ir = I_HALT;
    fetch_a();
    want(1'b0, B_RUN);
    repeat (20) want(1'b0, 27'd0);
    go(I_HALT, 24);
    do_reset();
    short_a("after_halt", I_NOP);

    check("queue_drained", 27'(exp_q.size()), 27'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
